pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: byte-serial instruction fetch/decode/execute sequencer with jump and halt support.
module pc_sequencer #(
  parameter logic [22:0] RESET_PC = 23'h000000,
  parameter logic [7:0]  HALT_OP  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        imm_req,
  input  logic        exec_stall,
  input  logic        resume,
  input  logic        jmp_pcoe,
  input  logic [22:0] jmp_pcout,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic [7:0]  ir,
  output logic [15:0] operand,
  output logic [22:0] pc,
  output logic        jmp_oe,
  output logic        halted,
  output logic [15:0] retired
);
  typedef enum logic [2:0] {FETCH_OP, DECODE, FETCH_LO, FETCH_HI, EXEC, HALTED} state_t;
  state_t      state_q, state_d;
  logic [22:0] pc_q, pc_d, pc_inc;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] operand_q, operand_d, retired_q, retired_d;
  assign pc_inc   = pc_q + 23'd1;
  assign mem_req  = state_q == FETCH_OP || state_q == FETCH_LO || state_q == FETCH_HI;
  assign mem_addr = pc_q;
  assign ir       = ir_q;
  assign operand  = operand_q;
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign jmp_oe   = state_q == EXEC && !exec_stall;
  assign halted   = state_q == HALTED;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    retired_d = retired_q;
    case (state_q)
      FETCH_OP: if (mem_ack) begin
        ir_d    = mem_rdata;
        pc_d    = pc_inc;
        state_d = DECODE;
      end
      DECODE: begin
        operand_d = imm_req ? operand_q : 16'h0000;
        state_d   = imm_req ? FETCH_LO : EXEC;
      end
      FETCH_LO: if (mem_ack) begin
        operand_d[7:0] = mem_rdata;
        pc_d           = pc_inc;
        state_d        = FETCH_HI;
      end
      FETCH_HI: if (mem_ack) begin
        operand_d[15:8] = mem_rdata;
        pc_d            = pc_inc;
        state_d         = EXEC;
      end
      // jmp_pcoe only matters in the single cycle jmp_oe is asserted
      EXEC: if (!exec_stall) begin
        retired_d = retired_q + 16'd1;
        pc_d      = jmp_pcoe ? jmp_pcout : pc_q;
        state_d   = ir_q == HALT_OP ? HALTED : FETCH_OP;
      end
      HALTED:  state_d = resume ? FETCH_OP : HALTED;
      default: state_d = FETCH_OP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      operand_q <= 16'h0000;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against an instruction-level model.
module tb_pc_sequencer;
  logic        clk = 0, rst = 0, mem_ack = 0, imm_req, exec_stall = 0, resume = 0, jmp_pcoe = 0;
  logic [7:0]  mem_rdata = 0;
  logic [22:0] jmp_pcout = 0;
  logic        mem_req, jmp_oe, halted;
  logic [22:0] mem_addr, pc;
  logic [7:0]  ir;
  logic [15:0] operand, retired;
  int checks = 0, errors = 0;
  pc_sequencer dut (
    .clk(clk), .rst(rst), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .imm_req(imm_req),
    .exec_stall(exec_stall), .resume(resume), .jmp_pcoe(jmp_pcoe), .jmp_pcout(jmp_pcout),
    .mem_req(mem_req), .mem_addr(mem_addr), .ir(ir), .operand(operand), .pc(pc),
    .jmp_oe(jmp_oe), .halted(halted), .retired(retired)
  );
  always #5 clk = ~clk;
  // external opcode decoder: bit 5 marks a 16-bit operand, the halt opcode never carries one
  assign imm_req = ir[5] && ir != 8'hFF;
  task step(input logic r, input logic a, input logic [7:0] d, input logic s, input logic j,
            input logic [22:0] t, input logic res);
    @(posedge clk);
    #1;
    rst = r; mem_ack = a; mem_rdata = d; exec_stall = s; jmp_pcoe = j; jmp_pcout = t; resume = res;
    #1;
  endtask
  task test_reset;
    step(0, 1, 8'hAB, 0, 0, 0, 0);
    step(0, 1, 8'hAB, 0, 1, 23'h123, 1);
    step(1, 0, 8'h00, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mem_req: got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 23'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
    checks++; if (pc !== 23'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
    checks++; if (jmp_oe !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_oe_halt: got %b%b exp 00", jmp_oe, halted); end
    checks++; if (ir !== 8'h00 || operand !== 16'h0 || retired !== 16'h0) begin errors++; $display("FAIL reset_regs: got %h %h %h exp 00 0000 0000", ir, operand, retired); end
    step(1, 0, 8'h00, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || ir !== 8'h00 || pc !== 23'h0) begin errors++; $display("FAIL reset_ack_discard: got %b %h %h exp 1 00 0", mem_req, ir, pc); end
  endtask
  task test_basic;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h10, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h0) begin errors++; $display("FAIL basic_fetch0: got %b %h exp 1 0", mem_req, mem_addr); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (ir !== 8'h10 || pc !== 23'h1 || mem_req !== 1'b0 || jmp_oe !== 1'b0) begin errors++; $display("FAIL basic_decode: got %h %h %b %b exp 10 1 0 0", ir, pc, mem_req, jmp_oe); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (jmp_oe !== 1'b1 || operand !== 16'h0) begin errors++; $display("FAIL basic_exec: got %b %h exp 1 0000", jmp_oe, operand); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h1 || retired !== 16'h1 || pc !== 23'h1) begin errors++; $display("FAIL basic_next: got %b %h %h %h exp 1 1 1 1", mem_req, mem_addr, retired, pc); end
  endtask
  task test_imm_jump;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h20, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h34, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h1) begin errors++; $display("FAIL imm_lo_addr: got %b %h exp 1 1", mem_req, mem_addr); end
    step(1, 1, 8'h12, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h2) begin errors++; $display("FAIL imm_hi_addr: got %b %h exp 1 2", mem_req, mem_addr); end
    step(1, 0, 0, 0, 1, 23'h001234, 0);
    checks++; if (jmp_oe !== 1'b1 || operand !== 16'h1234 || ir !== 8'h20) begin errors++; $display("FAIL imm_exec: got %b %h %h exp 1 1234 20", jmp_oe, operand, ir); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h001234 || retired !== 16'h1) begin errors++; $display("FAIL imm_jump_target: got %b %h %h exp 1 001234 1", mem_req, mem_addr, retired); end
  endtask
  task test_wait_wrap_stall;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h20, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, i == 3, 8'h56, 0, 0, 0, 0);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h1 || pc !== 23'h1) begin errors++; $display("FAIL wait_hold%0d: got %b %h %h exp 1 1 1", i, mem_req, mem_addr, pc); end
    end
    step(1, 1, 8'h78, 0, 0, 0, 0);
    checks++; if (mem_addr !== 23'h2 || mem_req !== 1'b1) begin errors++; $display("FAIL wait_advance: got %h %b exp 2 1", mem_addr, mem_req); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (operand !== 16'h7856 || jmp_oe !== 1'b1 || pc !== 23'h3) begin errors++; $display("FAIL wait_operand: got %h %b %h exp 7856 1 3", operand, jmp_oe, pc); end
    step(1, 1, 8'h10, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 23'h7FFFFF, 0);
    step(1, 1, 8'h10, 0, 0, 0, 0);
    checks++; if (mem_addr !== 23'h7FFFFF || mem_req !== 1'b1) begin errors++; $display("FAIL wrap_fetch: got %h %b exp 7fffff 1", mem_addr, mem_req); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 23'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", pc); end
    step(1, 0, 0, 1, 1, 23'h555, 0);
    checks++; if (jmp_oe !== 1'b0 || pc !== 23'h0) begin errors++; $display("FAIL stall1: got %b %h exp 0 0", jmp_oe, pc); end
    step(1, 0, 0, 1, 0, 23'h555, 0);
    checks++; if (jmp_oe !== 1'b0 || pc !== 23'h0 || retired !== 16'h2) begin errors++; $display("FAIL stall2: got %b %h %h exp 0 0 2", jmp_oe, pc, retired); end
    step(1, 0, 0, 0, 0, 23'h555, 0);
    checks++; if (jmp_oe !== 1'b1) begin errors++; $display("FAIL stall_release: got %b exp 1", jmp_oe); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (jmp_oe !== 1'b0 || retired !== 16'h3 || mem_addr !== 23'h0 || mem_req !== 1'b1) begin errors++; $display("FAIL stall_after: got %b %h %h %b exp 0 3 0 1", jmp_oe, retired, mem_addr, mem_req); end
  endtask
  task test_halt;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'hFF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 23'h0, 0);
    checks++; if (jmp_oe !== 1'b1 || ir !== 8'hFF) begin errors++; $display("FAIL halt_exec: got %b %h exp 1 ff", jmp_oe, ir); end
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 8'hAB, 0, 1, 23'h42, 0);
      checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || jmp_oe !== 1'b0 || pc !== 23'h0 || retired !== 16'h1) begin errors++; $display("FAIL halt_hold%0d: got %b %b %b %h %h exp 1 0 0 0 1", i, halted, mem_req, jmp_oe, pc, retired); end
    end
    step(1, 0, 0, 0, 0, 0, 1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_resume_cycle: got %b exp 1", halted); end
    step(1, 1, 8'h20, 0, 0, 0, 0);
    checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 23'h0) begin errors++; $display("FAIL halt_resumed: got %b %b %h exp 0 1 0", halted, mem_req, mem_addr); end
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h34, 0, 0, 0, 0);
    step(0, 1, 8'h12, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h2) begin errors++; $display("FAIL halt_mid_hi: got %b %h exp 1 2", mem_req, mem_addr); end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 23'h0 || retired !== 16'h0 || operand !== 16'h0 || ir !== 8'h00 || mem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_mid_reset: got %h %h %h %h %b %b exp 0 0 0 00 1 0", pc, retired, operand, ir, mem_req, halted); end
  endtask
  task test_random;
    logic [7:0]  mem [256];
    logic [22:0] m_pc, tgt;
    logic [15:0] m_ret, exp_op;
    logic [7:0]  op, b;
    logic        take;
    int nb, d, s;
    foreach (mem[i]) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hFF) mem[i] = 8'h00;
    end
    step(0, 0, 0, 0, 0, 0, 0);
    m_pc = 23'h0;
    m_ret = 16'h0;
    op = 8'h00;
    for (int n = 0; n < 60; n++) begin
      nb = 1;
      exp_op = 16'h0;
      for (int k = 0; k < nb; k++) begin
        d = $urandom_range(0, 3);
        for (int w = 0; w <= d; w++) begin
          step(1, w == d, mem[m_pc[7:0]], 0, 1'($urandom), 23'($urandom), 1'($urandom));
          checks++; if (mem_req !== 1'b1 || mem_addr !== m_pc || retired !== m_ret) begin errors++; $display("FAIL rand_fetch i%0d b%0d: got %b %h %h exp 1 %h %h", n, k, mem_req, mem_addr, retired, m_pc, m_ret); end
        end
        b = mem[m_pc[7:0]];
        m_pc = m_pc + 23'd1;
        if (k == 0) begin
          op = b;
          step(1, 1, 8'h5A, 0, 1, 23'h7, 0);
          checks++; if (ir !== op || pc !== m_pc || mem_req !== 1'b0 || jmp_oe !== 1'b0) begin errors++; $display("FAIL rand_decode i%0d: got %h %h %b %b exp %h %h 0 0", n, ir, pc, mem_req, jmp_oe, op, m_pc); end
          if (op[5]) nb = 3;
        end else if (k == 1) exp_op[7:0] = b;
        else exp_op[15:8] = b;
      end
      s = $urandom_range(0, 2);
      for (int w = 0; w < s; w++) begin
        step(1, 1, 8'h00, 1, 1'($urandom), 23'($urandom), 0);
        checks++; if (jmp_oe !== 1'b0 || mem_req !== 1'b0 || pc !== m_pc) begin errors++; $display("FAIL rand_stall i%0d: got %b %b %h exp 0 0 %h", n, jmp_oe, mem_req, pc, m_pc); end
      end
      take = 1'($urandom);
      tgt = $urandom_range(0, 3) == 0 ? 23'h7FFFFF : 23'($urandom);
      step(1, 0, 0, 0, take, tgt, 0);
      checks++; if (jmp_oe !== 1'b1 || ir !== op || operand !== exp_op) begin errors++; $display("FAIL rand_exec i%0d: got %b %h %h exp 1 %h %h", n, jmp_oe, ir, operand, op, exp_op); end
      m_ret = m_ret + 16'd1;
      if (take) m_pc = tgt;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_imm_jump;
    test_wait_wrap_stall;
    test_halt;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
